// File: rtl/cpu_seq_pkg.sv
// ============================================================================
// cpu_seq_pkg : shared types and constants for the fetch/execute sequencer
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH1 = 3'd1,
    ST_FETCH2 = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } seq_state_t;

  localparam logic [7:0] HALT_OPCODE_DEFAULT = 8'h0F;
  localparam logic [7:0] PC_INC              = 8'd2;

endpackage

`default_nettype wire

// File: rtl/seq_pc_reg.sv
// ============================================================================
// seq_pc_reg : program counter with reset load, +2 advance and jump select
// Revision   : 1.0
// ============================================================================
`default_nettype none

module seq_pc_reg
  import cpu_seq_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       advance,
  input  logic       jump,
  input  logic [7:0] target,
  output logic [7:0] pc
);

  logic [7:0] pc_d;
  logic [7:0] pc_q;

  // 8-bit add wraps 8'hFE to 8'h00 naturally
  always_comb begin
    pc_d = pc_q;
    if (advance) begin
      pc_d = jump ? target : (pc_q + PC_INC);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/cpu_sequencer.sv
// ============================================================================
// cpu_sequencer : two-byte fetch / execute / write-back sequencer with PC
// Optional      : CPU_SEQ_SINGLE_STEP_EN adds a single-step input
// Revision      : 1.0
// ============================================================================
`default_nettype none

module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [7:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        halt_req,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic        rom_req,
  output logic [7:0]  rom_addr,
  input  logic [7:0]  rom_rdata,
  input  logic        rom_ready,
  input  logic        jump_cond,
  output logic [7:0]  opcode1,
  output logic [7:0]  opcode2,
  output logic        exec_stb,
  output logic        wb_stb,
  output logic [7:0]  pc,
  output logic        halted,
  output logic [15:0] retire_cnt
);

  seq_state_t  state_q, state_d;
  logic [7:0]  opcode1_q, opcode1_d;
  logic [7:0]  opcode2_q, opcode2_d;
  logic [15:0] retire_cnt_q, retire_cnt_d;
  logic [7:0]  pc_w;

`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic step_mode_q, step_mode_d;
  logic step_prev_q, step_prev_d;
  logic step_go_w;

  // Only a rising step launches an instruction, so a held step runs one.
  assign step_go_w = step && !step_prev_q && !run;
`endif

  always_comb begin
    state_d      = state_q;
    opcode1_d    = opcode1_q;
    opcode2_d    = opcode2_q;
    retire_cnt_d = retire_cnt_q;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    step_mode_d  = step_mode_q;
    step_prev_d  = step;
`endif
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH1;
      end
      ST_FETCH1: begin
        if (rom_ready) begin
          opcode1_d = rom_rdata;
          state_d   = ST_FETCH2;
        end
      end
      ST_FETCH2: begin
        if (rom_ready) begin
          opcode2_d = rom_rdata;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_WB;
      end
      ST_WB: begin
        retire_cnt_d = retire_cnt_q + 16'd1;
        if ((opcode1_q == HALT_OPCODE) || halt_req || !run) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH1;
        end
`ifdef CPU_SEQ_SINGLE_STEP_EN
        if (step_mode_q) state_d = ST_HALT;
        step_mode_d = 1'b0;
`endif
      end
      ST_HALT: begin
        if (run && !halt_req) begin
          state_d = ST_FETCH1;
        end
`ifdef CPU_SEQ_SINGLE_STEP_EN
        else if (step_go_w) begin
          state_d     = ST_FETCH1;
          step_mode_d = 1'b1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      opcode1_q    <= 8'h00;
      opcode2_q    <= 8'h00;
      retire_cnt_q <= 16'h0000;
`ifdef CPU_SEQ_SINGLE_STEP_EN
      step_mode_q  <= 1'b0;
      step_prev_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      opcode1_q    <= opcode1_d;
      opcode2_q    <= opcode2_d;
      retire_cnt_q <= retire_cnt_d;
`ifdef CPU_SEQ_SINGLE_STEP_EN
      step_mode_q  <= step_mode_d;
      step_prev_q  <= step_prev_d;
`endif
    end
  end

  seq_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .reset   (reset),
    .advance (state_q == ST_WB),
    .jump    (jump_cond),
    .target  (opcode2_q),
    .pc      (pc_w)
  );

  assign rom_req    = (state_q == ST_FETCH1) || (state_q == ST_FETCH2);
  assign rom_addr   = (state_q == ST_FETCH2) ? (pc_w + 8'd1) : pc_w;
  assign exec_stb   = (state_q == ST_EXEC);
  assign wb_stb     = (state_q == ST_WB);
  assign halted     = (state_q == ST_HALT);
  assign opcode1    = opcode1_q;
  assign opcode2    = opcode2_q;
  assign pc         = pc_w;
  assign retire_cnt = retire_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
// ============================================================================
// tb_cpu_sequencer : scoreboard bench for cpu_sequencer
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        halt_req;
  logic        rom_req;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_rdata;
  logic        rom_ready;
  logic        jump_cond;
  logic [7:0]  opcode1;
  logic [7:0]  opcode2;
  logic        exec_stb;
  logic        wb_stb;
  logic [7:0]  pc;
  logic        halted;
  logic [15:0] retire_cnt;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic        step = 1'b0;
`endif

  logic [7:0] rom [256];
  logic       rom_ready_en = 1'b1;
  logic       jump_wb = 1'b0;
  logic       jump_ex = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wb_cyc = 0;

  typedef struct {
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [7:0]  pc;
    logic [15:0] rc;
    int          gap;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rom_rdata = rom[rom_addr];
  assign rom_ready = rom_ready_en;
  assign jump_cond = (jump_wb & wb_stb) | (jump_ex & exec_stb);

  cpu_sequencer #(
    .RESET_PC    (8'h00),
    .HALT_OPCODE (8'h0F)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .halt_req   (halt_req),
`ifdef CPU_SEQ_SINGLE_STEP_EN
    .step       (step),
`endif
    .rom_req    (rom_req),
    .rom_addr   (rom_addr),
    .rom_rdata  (rom_rdata),
    .rom_ready  (rom_ready),
    .jump_cond  (jump_cond),
    .opcode1    (opcode1),
    .opcode2    (opcode2),
    .exec_stb   (exec_stb),
    .wb_stb     (wb_stb),
    .pc         (pc),
    .halted     (halted),
    .retire_cnt (retire_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: strobes are checked against the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (exec_stb) begin
        if (exp_q.size() == 0) begin
          check("exec_unexpected", 32'd1, 32'd0);
        end else begin
          check("exec_op1", opcode1, exp_q[0].op1);
          check("exec_op2", opcode2, exp_q[0].op2);
        end
      end
      if (wb_stb) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wb_op1", opcode1, e.op1);
          check("wb_op2", opcode2, e.op2);
          check("wb_pc", pc, e.pc);
          check("wb_retire", retire_cnt, e.rc);
          if (e.gap != 0) check("wb_gap", cyc - last_wb_cyc, e.gap);
        end
        last_wb_cyc = cyc;
      end
    end
  end

  // Entered in FETCH1; returns at the first cycle after write-back.
  task automatic run_instr(input logic [7:0] p, input logic [7:0] o1, input logic [7:0] o2,
                           input int stalls, input bit jwb, input bit jex, input bit hreq,
                           input logic [7:0] nxt, input int gap, input logic [15:0] rc);
    exp_t e;
    logic [7:0] p1;
    p1 = p + 8'd1;
    e.op1 = o1; e.op2 = o2; e.pc = p; e.rc = rc; e.gap = gap;
    exp_q.push_back(e);
    jump_wb = jwb; jump_ex = jex; halt_req = hreq;
    check("f1_req", rom_req, 1);
    check("f1_addr", rom_addr, p);
    if (stalls > 0) begin
      rom_ready_en = 1'b0;
      repeat (stalls) begin
        tick();
        check("stall_addr", rom_addr, p);
        check("stall_strobes", {exec_stb, wb_stb}, 2'b00);
      end
      rom_ready_en = 1'b1;
    end
    tick();
    check("f2_addr", rom_addr, p1);
    tick();
    check("exec_strobes", {exec_stb, wb_stb}, 2'b10);
    tick();
    check("wb_strobes", {exec_stb, wb_stb}, 2'b01);
    tick();
    check("next_pc", pc, nxt);
    check("post_wb_strobes", {exec_stb, wb_stb}, 2'b00);
    jump_wb = 1'b0; jump_ex = 1'b0; halt_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h12; rom[8'h01] = 8'h34; rom[8'h02] = 8'h56; rom[8'h03] = 8'h78;
    rom[8'h04] = 8'h01; rom[8'h05] = 8'h10; rom[8'h06] = 8'h0F; rom[8'h07] = 8'hAA;
    rom[8'h08] = 8'h09; rom[8'h09] = 8'h0A; rom[8'h10] = 8'h02; rom[8'h11] = 8'h40;
    rom[8'h12] = 8'h03; rom[8'h13] = 8'h40; rom[8'h40] = 8'h04; rom[8'h41] = 8'hFE;
    rom[8'h56] = 8'h07; rom[8'h57] = 8'hFE; rom[8'hFE] = 8'h05; rom[8'hFF] = 8'hFF;

    reset = 1'b1; run = 1'b0; halt_req = 1'b0;
    tick(); tick();
    check("rst_pc", pc, 8'h00);
    check("rst_req", rom_req, 0);
    check("rst_addr", rom_addr, 8'h00);
    check("rst_strobes", {exec_stb, wb_stb}, 2'b00);
    check("rst_halted", halted, 0);
    check("rst_retire", retire_cnt, 16'h0000);
    check("rst_ops", {opcode1, opcode2}, 16'h0000);
    reset = 1'b0;
    tick();
    check("idle_no_run", rom_req, 0);

    // Sequential, stall, jump, jump-ignored-in-exec and wrap cases
    run = 1'b1;
    tick();
    run_instr(8'h00, 8'h12, 8'h34, 0, 0, 0, 0, 8'h02, 0, 16'd0);
    check("retire_first", retire_cnt, 16'd1);
    run_instr(8'h02, 8'h56, 8'h78, 3, 0, 0, 0, 8'h04, 7, 16'd1);
    run_instr(8'h04, 8'h01, 8'h10, 0, 1, 0, 0, 8'h10, 4, 16'd2);
    run_instr(8'h10, 8'h02, 8'h40, 0, 0, 1, 0, 8'h12, 4, 16'd3);
    run_instr(8'h12, 8'h03, 8'h40, 0, 1, 0, 0, 8'h40, 4, 16'd4);
    run_instr(8'h40, 8'h04, 8'hFE, 0, 1, 0, 0, 8'hFE, 4, 16'd5);
    run_instr(8'hFE, 8'h05, 8'hFF, 0, 1, 0, 0, 8'hFF, 4, 16'd6);
    run_instr(8'hFF, 8'hFF, 8'h12, 0, 0, 0, 0, 8'h01, 4, 16'd7);
    run_instr(8'h01, 8'h34, 8'h56, 0, 1, 0, 0, 8'h56, 4, 16'd8);
    run_instr(8'h56, 8'h07, 8'hFE, 0, 1, 0, 0, 8'hFE, 4, 16'd9);
    run_instr(8'hFE, 8'h05, 8'hFF, 0, 0, 0, 1, 8'h00, 4, 16'd10);
    run = 1'b0;
    check("hreq_halted", halted, 1);
    check("hreq_req", rom_req, 0);
    check("hreq_retire", retire_cnt, 16'd11);
    tick();
    check("hold_halted", halted, 1);
    check("hold_pc", pc, 8'h00);

    // Halt opcode, resume, then reset in the middle of FETCH2
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0; run = 1'b1;
    tick();
    run_instr(8'h00, 8'h12, 8'h34, 0, 0, 0, 0, 8'h02, 0, 16'd0);
    run_instr(8'h02, 8'h56, 8'h78, 0, 0, 0, 0, 8'h04, 4, 16'd1);
    run_instr(8'h04, 8'h01, 8'h10, 0, 0, 0, 0, 8'h06, 4, 16'd2);
    run_instr(8'h06, 8'h0F, 8'hAA, 0, 0, 0, 0, 8'h08, 4, 16'd3);
    check("hop_halted", halted, 1);
    check("hop_req", rom_req, 0);
    check("hop_retire", retire_cnt, 16'd4);
    tick();
    check("resume_halted", halted, 0);
    check("resume_addr", rom_addr, 8'h08);
    check("resume_req", rom_req, 1);
    tick();
    check("resume_f2_addr", rom_addr, 8'h09);
    reset = 1'b1;
    tick();
    check("midrst_pc", pc, 8'h00);
    check("midrst_retire", retire_cnt, 16'h0000);
    check("midrst_req", rom_req, 0);
    check("midrst_op1", opcode1, 8'h00);
    check("midrst_halted", halted, 0);
    run = 1'b0;
    tick();

`ifdef CPU_SEQ_SINGLE_STEP_EN
    reset = 1'b0; run = 1'b1;
    tick();
    run_instr(8'h00, 8'h12, 8'h34, 0, 0, 0, 1, 8'h02, 0, 16'd0);
    run = 1'b0;
    tick();
    check("pre_step_halted", halted, 1);
    begin
      exp_t e;
      e.op1 = 8'h56; e.op2 = 8'h78; e.pc = 8'h02; e.rc = 16'd1; e.gap = 0;
      exp_q.push_back(e);
    end
    step = 1'b1;
    repeat (5) tick();
    step = 1'b0;
    repeat (3) tick();
    check("step_halted", halted, 1);
    check("step_retire", retire_cnt, 16'd2);
    check("step_pc", pc, 8'h04);
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle fetch/execute sequencer for the 8-bit two-byte-instruction CPU. It replaces the free-running clk/pc_clk pair.
- Fetches opcode1 and opcode2 from a byte-wide, handshaked program ROM.
- Holds both bytes stable for the controller and datapath.
- Issues one-cycle execute and write-back strobes.
- Owns the program counter: sequential +2 or jump to opcode2.
- Sits between the program ROM and the CPU top; all datapath state updates are gated by its strobes.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset
HALT_OPCODE, 8'h0F, opcode1 value that stops the sequencer after write-back

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high; clears all state
run  in  1  level; 1 allows leaving IDLE/HALT
halt_req  in  1  level; sampled in WB, forces HALT after current instruction
rom_req  out  1  fetch request to program ROM
rom_addr  out  8  fetch byte address
rom_rdata  in  8  ROM read data, valid when rom_ready=1
rom_ready  in  1  ROM data-valid; may stall indefinitely
jump_cond  in  1  from controller; sampled in WB only
opcode1  out  8  latched first instruction byte
opcode2  out  8  latched second byte (immediate/address/branch target)
exec_stb  out  1  one-cycle pulse; ALU/RAM-read sample enable
wb_stb  out  1  one-cycle pulse; qualifies regWrite and RAM write
pc  out  8  current instruction address
halted  out  1  1 while in HALT
retire_cnt  out  16  instructions completed; wraps at 16'hFFFF->0

Behaviour:
- Reset values: state=IDLE, pc=RESET_PC, opcode1=opcode2=8'h00, rom_req=0, rom_addr=RESET_PC, exec_stb=wb_stb=0, halted=0, retire_cnt=0. Reset wins over every other event, in any state.
- State transitions:
  - IDLE: run=1 -> FETCH1 next cycle.
  - FETCH1: rom_req=1, rom_addr=pc. On rom_ready=1, opcode1<=rom_rdata and go to FETCH2; otherwise stay (stall).
  - FETCH2: rom_req=1, rom_addr=pc+1 (mod 256; 8'hFF wraps to 8'h00). On rom_ready=1, opcode2<=rom_rdata and go to EXEC.
  - EXEC: exec_stb=1 for exactly one cycle -> WB.
  - WB: wb_stb=1 for exactly one cycle.
    - pc <= opcode2 if jump_cond=1, else pc+2 (mod 256; 8'hFE -> 8'h00).
    - retire_cnt increments.
    - Next state is HALT if opcode1==HALT_OPCODE or halt_req=1 or run=0; otherwise FETCH1.
  - HALT: halted=1, rom_req=0, pc held. run=1 and halt_req=0 -> FETCH1, and halted deasserts in that cycle.
- opcode1/opcode2 change only on their ROM-ready capture cycles; they are stable from the EXEC cycle through the WB cycle.
- Minimum instruction latency is 4 cycles (FETCH1, FETCH2, EXEC, WB) with zero ROM wait states; each ROM wait state adds 1 cycle.
- rom_ready while rom_req=0 is ignored.
- A HALT_OPCODE instruction still executes its own WB: the PC advances and retire_cnt counts it.
- halt_req or run=0 during fetch/exec has no effect until WB; the instruction in flight always completes.
- jump_cond is ignored outside WB.

Optional Feature:
- Macro: CPU_SEQ_SINGLE_STEP_EN.
- With the macro defined:
  - Extra input step (1 bit) is added.
  - In HALT, a step=1 cycle with run=0 runs exactly one instruction (FETCH1..WB), then returns to HALT regardless of run.
  - step held high starts only one instruction; it must drop before another step is taken.
- Without the macro: no step port; HALT exits only via run=1.

Decomposition:
- Shared package cpu_seq_pkg:
  - state enum (IDLE, FETCH1, FETCH2, EXEC, WB, HALT)
  - HALT_OPCODE default
  - PC increment constant 8'd2
- Natural sub-module: seq_pc_reg, holding the PC register, reset load, +2 wrap and jump mux.
- The FSM and opcode latches stay in cpu_sequencer.

Test Plan:
- Reset, run=1, ROM 0-wait, ROM[0..1]=8'h12,8'h34 -> rom_addr 0 then 1; opcode1=8'h12, opcode2=8'h34 in EXEC; exec_stb and wb_stb each 1 cycle; pc=8'h02; retire_cnt=1; 4 cycles total.
- rom_ready held low 3 cycles in FETCH1 -> rom_addr stays 8'h00, no strobes; the instruction completes 3 cycles later than the 0-wait case.
- Instruction at pc=8'h10 with opcode2=8'h40, jump_cond=1 in WB -> next fetch at rom_addr=8'h40; jump_cond=1 pulsed only in EXEC -> pc=8'h12.
- pc=8'hFE, no jump -> FETCH2 rom_addr=8'hFF, next pc=8'h00; jump to 8'hFF -> FETCH2 rom_addr=8'h00.
- opcode1=8'h0F at pc=8'h06 -> wb_stb pulses, pc=8'h08, halted=1, rom_req=0. Then run=1 -> fetch resumes at 8'h08. Reset asserted mid-FETCH2 -> IDLE, pc=8'h00, retire_cnt=0.
- (CPU_SEQ_SINGLE_STEP_EN) In HALT with run=0, step held high 5 cycles -> exactly one instruction retires, retire_cnt +1, halted=1 again.
